// File: rtl/fp_div_seq.sv
// Sequential floating-point divider: RESULT = IN_A / IN_B using a restoring
// mantissa divider (one quotient bit per cycle) with round-to-nearest-even.
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [EXP_W+MAN_W:0] IN_A,
    input  logic [EXP_W+MAN_W:0] IN_B,
    output logic                 READY,
    output logic                 DONE,
    output logic [EXP_W+MAN_W:0] RESULT,
    output logic [3:0]           EXCEPTION
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW    = EXP_W + 2;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int CNT_W = $clog2(MAN_W + 3);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [EW-1:0] EMAX     = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_ROUND, S_FINISH} state_t;

    state_t                  state;
    logic [W-1:0]            a_q, b_q;
    logic                    sign_q;
    logic signed [EW-1:0]    exp_q;
    logic [MAN_W+1:0]        rem_q;
    logic [MAN_W:0]          mb_q;
    logic [MAN_W+2:0]        quo_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    special_q;
    logic [W-1:0]            spec_res_q;
    logic [3:0]              spec_exc_q;

    // Operand classification
    logic [EXP_W-1:0]        a_exp, b_exp;
    logic [MAN_W-1:0]        a_frac, b_frac;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                    u_sign, u_special;
    logic [W-1:0]            u_res;
    logic [3:0]              u_exc;
    logic signed [EW-1:0]    u_exp;

    always_comb begin
        a_exp  = a_q[W-2:MAN_W];
        b_exp  = b_q[W-2:MAN_W];
        a_frac = a_q[MAN_W-1:0];
        b_frac = b_q[MAN_W-1:0];
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
        b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
        a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
        b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
        u_sign = a_q[W-1] ^ b_q[W-1];
        u_exp  = {2'b00, a_exp} - {2'b00, b_exp} + EW'(BIAS);

        u_special = 1'b1;
        u_res     = '0;
        u_exc     = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            u_res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            u_exc = 4'b1000;
        end else if (a_inf) begin
            u_res = {u_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_zero) begin
            u_res = {u_sign, EXP_ONES, {MAN_W{1'b0}}};
            u_exc = 4'b0100;
        end else if (a_zero || b_inf) begin
            u_res = {u_sign, {(W-1){1'b0}}};
        end else begin
            u_special = 1'b0;
        end
    end

    // One restoring step
    logic                    d_ge;
    logic [MAN_W+1:0]        d_diff, d_rem_next;

    always_comb begin
        d_ge       = (rem_q >= {1'b0, mb_q});
        d_diff     = d_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        d_rem_next = d_diff << 1;
    end

    // Normalise, round to nearest even, range check
    logic [MAN_W-1:0]        r_frac;
    logic                    r_g, r_s, r_up, r_ovf, r_unf;
    logic [MAN_W:0]          r_fsum;
    logic signed [EW-1:0]    r_exp, r_exp_fin;
    logic [W-1:0]            r_res;
    logic [3:0]              r_exc;

    always_comb begin
        if (quo_q[MAN_W+2]) begin
            r_frac = quo_q[MAN_W+1:2];
            r_g    = quo_q[1];
            r_s    = quo_q[0] | (rem_q != '0);
            r_exp  = exp_q;
        end else begin
            r_frac = quo_q[MAN_W:1];
            r_g    = quo_q[0];
            r_s    = (rem_q != '0);
            r_exp  = exp_q - EW'(1);
        end
        r_up      = r_g & (r_s | r_frac[0]);
        // The hidden leading one is always set, so a carry out of the
        // fraction is the mantissa overflow; the fraction is then all zero.
        r_fsum    = {1'b0, r_frac} + {{MAN_W{1'b0}}, r_up};
        r_exp_fin = r_exp + {{(EW-1){1'b0}}, r_fsum[MAN_W]};
        r_ovf     = (r_exp_fin >= EMAX);
        r_unf     = r_exp_fin[EW-1] | (r_exp_fin == '0);
        r_exc     = {2'b00, r_ovf, r_unf};
        if (r_ovf)
            r_res = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
        else if (r_unf)
            r_res = {sign_q, {(W-1){1'b0}}};
        else
            r_res = {sign_q, r_exp_fin[EXP_W-1:0], r_fsum[MAN_W-1:0]};
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            READY      <= 1'b1;
            DONE       <= 1'b0;
            RESULT     <= '0;
            EXCEPTION  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            mb_q       <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            spec_exc_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        a_q   <= IN_A;
                        b_q   <= IN_B;
                        READY <= 1'b0;
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_q     <= u_sign;
                    exp_q      <= u_exp;
                    rem_q      <= {1'b0, 1'b1, a_frac};
                    mb_q       <= {1'b1, b_frac};
                    quo_q      <= '0;
                    cnt_q      <= CNT_W'(MAN_W + 2);
                    special_q  <= u_special;
                    spec_res_q <= u_res;
                    spec_exc_q <= u_exc;
                    // Special operands pass through ROUND untouched so their
                    // DONE lands on the third edge after START.
                    state      <= u_special ? S_ROUND : S_DIVIDE;
                end
                S_DIVIDE: begin
                    rem_q <= d_rem_next;
                    quo_q <= {quo_q[MAN_W+1:0], d_ge};
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0)
                        state <= S_ROUND;
                end
                S_ROUND: begin
                    RESULT    <= special_q ? spec_res_q : r_res;
                    EXCEPTION <= special_q ? spec_exc_q : r_exc;
                    DONE      <= 1'b1;
                    state     <= S_FINISH;
                end
                S_FINISH: begin
                    DONE  <= 1'b0;
                    READY <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: single- and half-precision instances checked against
// an arithmetic reference model, with literal expectations pinning the model.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        start_f, ready_f, done_f;
    logic [31:0] in_a_f, in_b_f, result_f;
    logic [3:0]  exc_f;
    logic        start_h, ready_h, done_h;
    logic [15:0] in_a_h, in_b_h, result_h;
    logic [3:0]  exc_h;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  exc;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q_f[$];
    exp_t q_h[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut_f (
        .CLOCK(clk), .RESET(rst_n), .START(start_f), .IN_A(in_a_f), .IN_B(in_b_f),
        .READY(ready_f), .DONE(done_f), .RESULT(result_f), .EXCEPTION(exc_f)
    );

    fp_div_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
        .CLOCK(clk), .RESET(rst_n), .START(start_h), .IN_A(in_a_h), .IN_B(in_b_h),
        .READY(ready_h), .DONE(done_h), .RESULT(result_h), .EXCEPTION(exc_h)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: exact integer quotient, then textbook RNE on the dropped bits.
    function automatic void model(input int ew, input int mw, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] res,
                                  output logic [3:0] exc, output int lat);
        longint unsigned emax, fmask, ea, eb, fa, fb, s, ma, mb, num, qt, rm, mant, rest, half;
        longint e, bias;
        int w, sh;
        logic up, za, zb, ia, ib, na, nb;
        w     = 1 + ew + mw;
        emax  = (64'd1 << ew) - 1;
        fmask = (64'd1 << mw) - 1;
        bias  = (64'd1 << (ew - 1)) - 1;
        ea = (64'(a) >> mw) & emax;  fa = 64'(a) & fmask;
        eb = (64'(b) >> mw) & emax;  fb = 64'(b) & fmask;
        s  = ((64'(a) >> (w - 1)) ^ (64'(b) >> (w - 1))) & 64'd1;
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == emax) && (fa == 0); ib = (eb == emax) && (fb == 0);
        na = (ea == emax) && (fa != 0); nb = (eb == emax) && (fb != 0);
        exc = 4'b0000;
        lat = 3;
        if (na || nb || (za && zb) || (ia && ib)) begin
            res = 32'((emax << mw) | (64'd1 << (mw - 1)));
            exc = 4'b1000;
        end else if (ia) begin
            res = 32'((s << (w - 1)) | (emax << mw));
        end else if (zb) begin
            res = 32'((s << (w - 1)) | (emax << mw));
            exc = 4'b0100;
        end else if (za || ib) begin
            res = 32'(s << (w - 1));
        end else begin
            lat = mw + 6;
            ma  = (64'd1 << mw) | fa;
            mb  = (64'd1 << mw) | fb;
            num = ma << (mw + 2);
            qt  = num / mb;
            rm  = num % mb;
            e   = longint'(ea) - longint'(eb) + bias;
            if (qt >= (64'd1 << (mw + 2))) sh = 2;
            else begin sh = 1; e = e - 1; end
            mant = qt >> sh;
            rest = qt & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            up   = (rest > half) || ((rest == half) && ((rm != 0) || mant[0]));
            mant = mant + 64'(up);
            if (mant == (64'd1 << (mw + 1))) begin mant = mant >> 1; e = e + 1; end
            if (e >= longint'(emax)) begin
                res = 32'((s << (w - 1)) | (emax << mw));
                exc = 4'b0010;
            end else if (e <= 0) begin
                res = 32'(s << (w - 1));
                exc = 4'b0001;
            end else begin
                res = 32'((s << (w - 1)) | (64'(e) << mw) | (mant & fmask));
            end
        end
    endfunction

    // Called on a falling edge; returns on the falling edge after START.
    task automatic issue(input int which, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit_res, input logic [3:0] lit_exc);
        exp_t e;
        int n = 0;
        if (which == 0) model(8, 23, a, b, e.res, e.exc, e.lat);
        else            model(5, 10, a, b, e.res, e.exc, e.lat);
        check($sformatf("model_res %0h/%0h", a, b), e.res, lit_res);
        check($sformatf("model_exc %0h/%0h", a, b), e.exc, lit_exc);
        while (((which == 0) ? ready_f : ready_h) !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", 0, 1);
        e.t0 = cyc;
        if (which == 0) begin
            in_a_f = a; in_b_f = b; start_f = 1'b1; q_f.push_back(e);
        end else begin
            in_a_h = a[15:0]; in_b_h = b[15:0]; start_h = 1'b1; q_h.push_back(e);
        end
        @(negedge clk);
        start_f = 1'b0;
        start_h = 1'b0;
    endtask

    always @(negedge clk) begin : cmp
        exp_t e;
        if (done_f === 1'b1) begin
            if (q_f.size() == 0) check("unexpected_done_f", 1, 0);
            else begin
                e = q_f.pop_front();
                check("result_f", result_f, e.res);
                check("exception_f", exc_f, e.exc);
                check("latency_f", cyc - e.t0, e.lat);
                check("ready_at_done_f", ready_f, 0);
            end
        end else if (q_f.size() != 0 && cyc > q_f[0].t0) begin
            check("ready_busy_f", ready_f, 0);
        end
        if (done_h === 1'b1) begin
            if (q_h.size() == 0) check("unexpected_done_h", 1, 0);
            else begin
                e = q_h.pop_front();
                check("result_h", result_h, e.res[15:0]);
                check("exception_h", exc_h, e.exc);
                check("latency_h", cyc - e.t0, e.lat);
                check("ready_at_done_h", ready_h, 0);
            end
        end else if (q_h.size() != 0 && cyc > q_h[0].t0) begin
            check("ready_busy_h", ready_h, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drain();
        int n = 0;
        while ((q_f.size() != 0 || q_h.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 0, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start_f = 1'b0; in_a_f = '0; in_b_f = '0;
        start_h = 1'b0; in_a_h = '0; in_b_h = '0;
        repeat (3) @(negedge clk);
        check("reset_ready_f", ready_f, 1);
        check("reset_done_f", done_f, 0);
        check("reset_result_f", result_f, 0);
        check("reset_exc_f", exc_f, 0);
        check("reset_ready_h", ready_h, 1);
        check("reset_result_h", result_h, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
        issue(0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);
        issue(0, 32'hBFC00000, 32'h3F000000, 32'hC0400000, 4'b0000);
        issue(0, 32'h3F800000, 32'h80000000, 32'hFF800000, 4'b0100);
        issue(0, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000);
        issue(0, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000);
        issue(0, 32'h00000000, 32'h40000000, 32'h00000000, 4'b0000);
        issue(0, 32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010);
        issue(0, 32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001);
        issue(0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000);
        issue(0, 32'h40000000, 32'hC0800000, 32'hBF000000, 4'b0000);
        issue(0, 32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000);
        issue(0, 32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000);
        issue(0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        issue(0, 32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000);
        issue(0, 32'h3F800000, 32'h00400000, 32'h7F800000, 4'b0100);

        issue(1, 32'h4600, 32'h4000, 32'h4200, 4'b0000);
        issue(1, 32'h3C00, 32'h4200, 32'h3555, 4'b0000);
        issue(1, 32'h3C00, 32'h0000, 32'h7C00, 4'b0100);
        issue(1, 32'h7800, 32'h0400, 32'h7C00, 4'b0010);
        drain();

        // START while busy must be ignored
        issue(0, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
        repeat (5) @(negedge clk);
        in_a_f = 32'h3F800000; in_b_f = 32'h40400000; start_f = 1'b1;
        @(negedge clk);
        start_f = 1'b0;
        drain();

        // Reset mid-divide: outputs clear at once and no DONE follows
        issue(0, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ready", ready_f, 1);
        check("midreset_done", done_f, 0);
        check("midreset_result", result_f, 0);
        check("midreset_exc", exc_f, 0);
        q_f.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(0, 32'hBFC00000, 32'h3F000000, 32'hC0400000, 4'b0000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
